max_pool_unit: RTL and testbench
================================

# max_pool_unit

Parametrised multi-channel pooling reducer for the CNN feature-map datapath, successor to the single-lane running-maximum register. Reduces each group of WINDOW consecutive accepted input beats to one result per channel, in MAX or MIN mode, and reports the winning position within the window. Sits between the convolution/activation stage and the fully-connected stage. Uses valid/ready handshakes on both sides and applies back-pressure when the output is stalled.

## Interface
- DATA_WIDTH, 32, signed two's-complement element width
- CHANNELS, 4, parallel independent lanes (≥1)
- WINDOW, 4, accepted beats per pooling window (≥1)
- IDX_WIDTH, max(1, clog2(WINDOW)), width of each lane's index field
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous abort: discards the partial window and any pending output
- mode  in  1  0 = MAX, 1 = MIN; sampled on the first beat of each window
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  CHANNELS*DATA_WIDTH  lane c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_data  out  CHANNELS*DATA_WIDTH  per-lane pooled value, same packing as in_data
- out_index  out  CHANNELS*IDX_WIDTH  per-lane beat position (0..WINDOW-1) of the winner

## Operation
- Beat counter cnt runs 0..WINDOW-1 and advances on each accepted beat. It wraps to 0 after the last beat.
- First beat (cnt==0):
  - Each lane loads in_data directly into its accumulator; index is set to 0.
  - mode is latched into win_mode.
  - No sentinel value takes part in the comparison.
- Later beats, per lane, using signed compare:
  - MAX: replace when in > acc.
  - MIN: replace when in < acc.
  - On replace, index := cnt.
  - Ties keep the earlier beat.
- Changes to mode in mid-window are ignored until the next window starts.
- Last beat (cnt==WINDOW-1): the final comparison result is written into the output register, and out_valid is set.
- The output register holds its value while out_valid & ~out_ready.
- Accumulation of the next window continues while the output is stalled. Only the last beat of that window is blocked.
- in_ready = ~(out_valid & ~out_ready & cnt==WINDOW-1). This path is combinational from out_ready.
- Simultaneous out handshake and last beat: the old result is consumed and the new result is loaded on the same edge; out_valid stays 1.
- clear has priority over every handshake in that cycle. It sets cnt:=0 and out_valid:=0, and drops any beat presented in that cycle.
- WINDOW==1: every accepted beat produces a result with index 0.
- Reset values:
  - out_valid 0, out_data 0, out_index 0
  - cnt 0, win_mode 0 (MAX), accumulators 0
  - in_ready 1 while rst is deasserted and out_valid is 0

## Timing
- Latency: last beat accepted at edge N → out_valid=1 and result visible after edge N.
- Throughput: 1 beat/cycle. Windows run back-to-back with no bubble while out_ready=1.
- rst asserted at any time, including mid-window or with out_valid high: all state goes to reset values immediately. The first beat after rst deasserts starts a fresh window.
- clear takes effect at the next edge. The first beat accepted after that edge is beat 0.

## Structure
- Package pool_pkg: MODE_MAX/MODE_MIN constants, IDX_WIDTH helper function, and the signed compare-select function.
- Sub-module pool_lane:
  - One per channel, via generate.
  - Holds the accumulator and index registers and the compare logic.
  - Receives first/last/cnt/win_mode from the top.
- The top holds cnt, win_mode, the output register, and the handshake logic.

## Test plan
- All scenarios use DATA_WIDTH=8, CHANNELS=2, WINDOW=4 unless stated otherwise.
- MAX, tie handling: lane0 beats 3, -5, 7, 7 → out 7, index 2. Lane1 beats -128 ×4 → out -128, index 0.
- MIN with mode toggled mid-window: mode=1 on beat 0, mode=0 on beat 2; lane0 beats 10, -128, 5, -100 → out -128, index 1 (mode latched on beat 0).
- Back-pressure:
  - Hold out_ready=0 after window A.
  - Window B beats 0-2 are accepted; beat 3 sees in_ready=0.
  - Raise out_ready: window A is consumed, B's beat 3 is accepted on the same edge, and out_valid stays 1 with B's result.
- clear mid-window: clear after 2 beats, then beats 1, 2, 3, 4 → out 4, index 3. No stale result appears.
- Async reset mid-window with out_valid=1: out_valid drops without a clock edge and in_ready=1. The next 4 beats form a fresh window.
- WINDOW=1 build, out_ready=1: stream 1, -2, 3 → outputs 1, -2, 3 on consecutive cycles, all index 0, in_ready constantly 1.

Source files
------------

// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pool_pkg
// Purpose  : Shared constants and helpers for the max_pool_unit datapath:
//            pooling mode encodings, index-width helper, and the signed
//            compare-select used by every lane.
// Revision : 1.0 - initial release
// ============================================================================
package pool_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  // Common width used for the signed comparison; lanes sign-extend into it.
  // It supports element widths up to 64 bits.
  localparam int CMP_WIDTH = 64;

  // Width of a beat-position field. It is at least one bit, so a one-beat
  // window still has a well-formed port.
  function automatic int idx_width(input int window);
    return (window > 2) ? $clog2(window) : 1;
  endfunction

  // True when the candidate must replace the incumbent. On a tie this
  // returns false, so the earlier beat wins.
  function automatic logic take_new(input logic                        mode,
                                    input logic signed [CMP_WIDTH-1:0] cand,
                                    input logic signed [CMP_WIDTH-1:0] inc);
    return (mode == MODE_MIN) ? (cand < inc) : (cand > inc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_lane.sv
`default_nettype none
// ============================================================================
// Module   : pool_lane
// Purpose  : One pooling lane. It holds the running accumulator and the
//            winning beat index. It also exposes the post-beat result, so
//            the top can capture the last beat's outcome directly.
// Revision : 1.0 - initial release
// ============================================================================
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat,
  input  logic                  first,
  input  logic                  win_mode,
  input  logic [IDX_WIDTH-1:0]  cnt,
  input  logic [DATA_WIDTH-1:0] in_lane,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [IDX_WIDTH-1:0]  res_idx
);

  logic [DATA_WIDTH-1:0] acc;
  logic [IDX_WIDTH-1:0]  idx;
  logic                  take;

  // Result after the current beat. The first beat loads unconditionally,
  // and later beats replace the accumulator only on a strict win.
  always_comb begin
    take     = first | take_new(win_mode,
                                CMP_WIDTH'($signed(in_lane)),
                                CMP_WIDTH'($signed(acc)));
    res_data = take ? in_lane : acc;
    res_idx  = first ? '0 : (take ? cnt : idx);
  end

  // Accumulator and index registers advance only on accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
    end else if (beat) begin
      acc <= res_data;
      idx <= res_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/max_pool_unit.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_unit
// Purpose  : Multi-channel MAX/MIN pooling reducer with valid/ready on both
//            sides. It reduces every WINDOW accepted beats to one result per
//            lane and reports the winning beat position.
// Revision : 1.0 - initial release
// ============================================================================
module max_pool_unit
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 4,
  parameter int WINDOW     = 4,
  parameter int IDX_WIDTH  = idx_width(WINDOW)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [CHANNELS*IDX_WIDTH-1:0]  out_index
);

  localparam logic [IDX_WIDTH-1:0] LAST_CNT = IDX_WIDTH'(WINDOW - 1);

  logic [IDX_WIDTH-1:0]           cnt;
  logic                           win_mode;
  logic                           first;
  logic                           last;
  logic                           accept;
  logic [CHANNELS*DATA_WIDTH-1:0] res_data;
  logic [CHANNELS*IDX_WIDTH-1:0]  res_index;

  // Window position decode and handshake. Only the closing beat can be
  // stalled, because it is the only beat that needs the output register.
  always_comb begin
    first    = (cnt == '0);
    last     = (cnt == LAST_CNT);
    in_ready = ~(out_valid & ~out_ready & last);
    accept   = in_valid & in_ready & ~clear;
  end

  // Per-lane compare/accumulate slices.
  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      pool_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .beat     (accept),
        .first    (first),
        .win_mode (win_mode),
        .cnt      (cnt),
        .in_lane  (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
        .res_data (res_data[c*DATA_WIDTH +: DATA_WIDTH]),
        .res_idx  (res_index[c*IDX_WIDTH +: IDX_WIDTH])
      );
    end
  endgenerate

  // Beat counter and window mode. Mode is captured on beat 0 only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      win_mode <= MODE_MAX;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last ? '0 : cnt + IDX_WIDTH'(1);
      if (first) win_mode <= mode;
    end
  end

  // Output register. A closing beat reloads it even while a consume
  // happens on the same edge, so out_valid stays high with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (accept && last) begin
      out_valid <= 1'b1;
      out_data  <= res_data;
      out_index <= res_index;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_max_pool_unit
// Purpose  : Self-checking bench for max_pool_unit (WINDOW=4 and WINDOW=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_pool_unit;

  localparam int DW = 8;
  localparam int CH = 2;
  localparam int W  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (WINDOW=4)
  logic            clear = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [CH*DW-1:0] in_data = '0;
  logic            in_ready, out_valid;
  logic [CH*DW-1:0] out_data;
  logic [CH*IW-1:0] out_index;

  max_pool_unit #(.DATA_WIDTH(DW), .CHANNELS(CH), .WINDOW(W)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index)
  );

  // Second instance (WINDOW=1)
  logic            in1_valid = 1'b0;
  logic [CH*DW-1:0] in1_data = '0;
  logic            in1_ready, out1_valid;
  logic [CH*DW-1:0] out1_data;
  logic [CH-1:0]   out1_index;

  max_pool_unit #(.DATA_WIDTH(DW), .CHANNELS(CH), .WINDOW(1)) u_w1 (
    .clk(clk), .rst(rst), .clear(1'b0), .mode(1'b0),
    .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data),
    .out_valid(out1_valid), .out_ready(1'b1),
    .out_data(out1_data), .out_index(out1_index)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] lane(input logic [CH*DW-1:0] v, input int c);
    return v[c*DW +: DW];
  endfunction

  // ---------------- behavioural model + compare process ----------------
  logic [CH*DW-1:0] exp_d[$];
  logic [CH*IW-1:0] exp_i[$];
  logic signed [DW-1:0] wb[W][CH];
  int   nb = 0;
  logic wm = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_d.delete(); exp_i.delete(); nb = 0;
    end else begin
      chk("in_ready", longint'(in_ready),
          longint'(!(exp_d.size() > 0 && !out_ready && nb == W-1)));
      chk("out_valid", longint'(out_valid), longint'(exp_d.size() > 0));
      if (out_valid && exp_d.size() > 0) begin
        chk("model_out_data", longint'(out_data), longint'(exp_d[0]));
        chk("model_out_index", longint'(out_index), longint'(exp_i[0]));
      end
      if (clear) begin
        exp_d.delete(); exp_i.delete(); nb = 0;
      end else begin
        if (out_valid && out_ready && exp_d.size() > 0) begin
          void'(exp_d.pop_front()); void'(exp_i.pop_front());
        end
        if (in_valid && in_ready) begin
          if (nb == 0) wm = mode;
          for (int c = 0; c < CH; c++) wb[nb][c] = lane(in_data, c);
          nb++;
          if (nb == W) begin
            logic [CH*DW-1:0] d;
            logic [CH*IW-1:0] ix;
            for (int c = 0; c < CH; c++) begin
              logic signed [DW-1:0] best;
              int bi;
              best = wb[0][c]; bi = 0;
              for (int k = 1; k < W; k++)
                if (wm ? (wb[k][c] < best) : (wb[k][c] > best)) begin
                  best = wb[k][c]; bi = k;
                end
              d[c*DW +: DW]  = best;
              ix[c*IW +: IW] = IW'(bi);
            end
            exp_d.push_back(d); exp_i.push_back(ix);
            nb = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                      input logic m);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = {b, a}; mode = m;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic lit_out(input string name,
                         input longint d0, input longint i0,
                         input longint d1, input longint i1);
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk({name, "_d0"}, longint'(lane(out_data, 0)), d0);
    chk({name, "_i0"}, longint'(out_index[0 +: IW]), i0);
    chk({name, "_d1"}, longint'(lane(out_data, 1)), d1);
    chk({name, "_i1"}, longint'(out_index[IW +: IW]), i1);
  endtask

  logic signed [DW-1:0] w1v[3] = '{8'sd1, -8'sd2, 8'sd3};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_index", longint'(out_index), 0);

    // MAX with ties
    send(3, -128, 0); send(-5, -128, 0); send(7, -128, 0); send(7, -128, 0);
    lit_out("max_tie", 7, 2, -128, 0);
    @(posedge clk); #1;

    // MIN latched on beat 0, mode toggled mid-window
    send(10, 1, 1); send(-128, 2, 1); send(5, 3, 0); send(-100, 4, 0);
    lit_out("min_latch", -128, 1, 1, 0);
    @(posedge clk); #1;

    // Back-pressure
    out_ready = 1'b0;
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0);
    lit_out("bp_a", 4, 3, 0, 0);
    send(-1, 5, 0); send(-2, 6, 0); send(-3, 7, 0);
    in_valid = 1'b1; in_data = {8'sd8, -8'sd4};
    @(negedge clk);
    chk("bp_in_ready_low", longint'(in_ready), 0);
    @(posedge clk); #1;
    lit_out("bp_hold", 4, 3, 0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_high", longint'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lit_out("bp_b", -1, 0, 8, 3);

    // clear mid-window
    send(9, 9, 0); send(8, 8, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = {8'sd100, 8'sd100};
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_out_valid", longint'(out_valid), 0);
    send(1, 1, 0); send(2, 2, 0); send(3, 3, 0);
    chk("clear_no_stale", longint'(out_valid), 0);
    send(4, 4, 0);
    lit_out("clear_win", 4, 3, 4, 3);
    @(posedge clk); #1;

    // Async reset with out_valid high, mid-window
    out_ready = 1'b0;
    send(11, 0, 0); send(12, 0, 0); send(13, 0, 0); send(14, 0, 0);
    send(20, 0, 0); send(21, 0, 0);
    chk("pre_rst_valid", longint'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", longint'(out_valid), 0);
    chk("arst_in_ready", longint'(in_ready), 1);
    chk("arst_out_data", longint'(out_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    send(5, -8, 0); send(6, -7, 0); send(7, -6, 0); send(8, -5, 0);
    lit_out("post_rst", 8, 3, -5, 3);
    @(posedge clk); #1;

    // WINDOW=1 instance
    for (int k = 0; k < 3; k++) begin
      in1_valid = 1'b1; in1_data = {8'sd0, w1v[k]};
      @(negedge clk);
      chk("w1_in_ready", longint'(in1_ready), 1);
      @(posedge clk); #1;
      chk("w1_valid", longint'(out1_valid), 1);
      chk("w1_data", longint'(lane(out1_data, 0)), longint'(w1v[k]));
      chk("w1_index", longint'(out1_index), 0);
    end
    in1_valid = 1'b0;
    @(posedge clk); #1;
    chk("w1_drain", longint'(out1_valid), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
